// File: rtl/char_text_buffer_if.sv
// Text RAM write port between game logic and the character text buffer.
// Plain valid/ready handshake; a write commits when wr_valid && wr_ready.
interface char_text_buffer_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] wr_addr;
   logic [6:0] wr_char;

   modport master (
      output wr_valid,
      output wr_addr,
      output wr_char,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_addr,
      input  wr_char,
      output wr_ready
   );
endinterface

// File: rtl/char_text_buffer.sv
// Character text buffer: 16x16 text RAM, font lookup pipeline, clear FSM.
// Optional CHAR_CURSOR_EN adds a cursor cell drawn with inverted pixels.
module char_text_buffer #(
   parameter logic [6:0] CLEAR_CHAR = 7'h20,
   parameter int         CLEAR_LEN  = 256
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [7:0]  char_xy,
   input  logic [3:0]  char_line,
   output logic [7:0]  char_pixels,
   output logic [10:0] font_addr,
   input  logic [7:0]  font_data,
`ifdef CHAR_CURSOR_EN
   input  logic [7:0]  cursor_pos,
   input  logic        cursor_on,
`endif
   char_text_buffer_if.slave wr,
   input  logic        clear_req,
   output logic        busy
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   localparam logic [7:0] LAST_CELL = 8'(CLEAR_LEN - 1);

   logic [6:0]  mem [256];

   state_e      state_q, state_d;
   logic [7:0]  clr_cnt_q, clr_cnt_d;
   logic [10:0] font_addr_q, font_addr_d;
   logic [7:0]  pix_q, pix_d;

   logic        ram_we;
   logic [7:0]  ram_waddr;
   logic [6:0]  ram_wdata;

`ifdef CHAR_CURSOR_EN
   logic        cur1_q, cur1_d;
   logic        cur2_q, cur2_d;
`endif

   assign busy        = (state_q == ST_CLEAR) || rst;
   assign wr.wr_ready = (state_q == ST_IDLE) && !clear_req && !rst;
   assign font_addr   = font_addr_q;
   assign char_pixels = pix_q;

   // Clear sweep: next state and clear counter
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (clear_req) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = 8'd0;
            end
         end
         ST_CLEAR: begin
            if (clear_req) begin
               clr_cnt_d = 8'd0;
            end else begin
               clr_cnt_d = clr_cnt_q + 8'd1;
               if (clr_cnt_q == LAST_CELL) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_cnt_d = 8'd0;
         end
      endcase
   end

   // FSM state register; reset starts a full clear
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // RAM write select: clear sweep owns the port while busy
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = wr.wr_addr;
      ram_wdata = wr.wr_char;
      if (!rst) begin
         if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt_q;
            ram_wdata = CLEAR_CHAR;
         end else if (wr.wr_valid && wr.wr_ready) begin
            ram_we = 1'b1;
         end
      end
   end

   // Text RAM write port; no reset on the array
   always_ff @(posedge pclk) begin
      if (ram_we) begin
         mem[ram_waddr] <= ram_wdata;
      end
   end

   // Lookup pipeline: RAM read into font_addr, ROM data into pixels
   always_comb begin
      font_addr_d = {mem[char_xy], char_line};
      pix_d       = font_data;
`ifdef CHAR_CURSOR_EN
      cur1_d = (char_xy == cursor_pos);
      cur2_d = cur1_q;
      if (cur2_q && cursor_on) begin
         pix_d = ~font_data;
      end
`endif
   end

   // Pipeline registers; runs every cycle, clear or not
   always_ff @(posedge pclk) begin
      if (rst) begin
         font_addr_q <= 11'd0;
         pix_q       <= 8'd0;
`ifdef CHAR_CURSOR_EN
         cur1_q      <= 1'b0;
         cur2_q      <= 1'b0;
`endif
      end else begin
         font_addr_q <= font_addr_d;
         pix_q       <= pix_d;
`ifdef CHAR_CURSOR_EN
         cur1_q      <= cur1_d;
         cur2_q      <= cur2_d;
`endif
      end
   end

endmodule

// File: tb/tb_char_text_buffer.sv
// Directed bench for char_text_buffer with a registered font ROM model.
// Define CHAR_CURSOR_EN to also exercise the cursor inversion.
module tb_char_text_buffer;

   logic        pclk = 1'b0;
   logic        rst;
   logic [7:0]  char_xy;
   logic [3:0]  char_line;
   logic [7:0]  char_pixels;
   logic [10:0] font_addr;
   logic [7:0]  font_data;
   logic        clear_req;
   logic        busy;
`ifdef CHAR_CURSOR_EN
   logic [7:0]  cursor_pos;
   logic        cursor_on;
`endif

   int n_vec = 0;
   int n_err = 0;

   char_text_buffer_if wif ();

   char_text_buffer dut (
      .pclk        (pclk),
      .rst         (rst),
      .char_xy     (char_xy),
      .char_line   (char_line),
      .char_pixels (char_pixels),
      .font_addr   (font_addr),
      .font_data   (font_data),
`ifdef CHAR_CURSOR_EN
      .cursor_pos  (cursor_pos),
      .cursor_on   (cursor_on),
`endif
      .wr          (wif.slave),
      .clear_req   (clear_req),
      .busy        (busy)
   );

   always #5 pclk = ~pclk;

   // Font ROM stand-in: one known glyph row, a simple hash elsewhere
   function automatic logic [7:0] rom_f(input logic [10:0] a);
      if (a == 11'h415) return 8'hA5;
      return a[7:0] ^ {a[10:4], 1'b0};
   endfunction

   // Registered ROM read, one cycle behind font_addr
   always @(posedge pclk) font_data <= rom_f(font_addr);

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 600) begin
         tick();
         n++;
      end
   endtask

   task automatic write_cell(input logic [7:0] a, input logic [6:0] c);
      wif.wr_valid = 1'b1;
      wif.wr_addr  = a;
      wif.wr_char  = c;
      tick();
      wif.wr_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
   endtask

   logic [6:0] codes [16];

   initial begin
      int n;
      rst          = 1'b1;
      char_xy      = 8'h00;
      char_line    = 4'd0;
      clear_req    = 1'b0;
      wif.wr_valid = 1'b0;
      wif.wr_addr  = 8'h00;
      wif.wr_char  = 7'h00;
`ifdef CHAR_CURSOR_EN
      cursor_pos   = 8'h23;
      cursor_on    = 1'b0;
`endif
      repeat (3) tick();
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_ready", 32'(wif.wr_ready), 32'd0);
      chk("rst_faddr", 32'(font_addr), 32'h0);
      chk("rst_pix", 32'(char_pixels), 32'h0);

      rst = 1'b0;
      wait_idle(n);
      chk("init_clear_len", 32'(n), 32'd256);
      chk("init_ready", 32'(wif.wr_ready), 32'd1);

      char_xy   = 8'h7C;
      char_line = 4'd9;
      tick();
      chk("blank_faddr_a", 32'(font_addr), 32'h209);
      char_xy   = 8'hFF;
      char_line = 4'd3;
      tick();
      chk("blank_faddr_b", 32'(font_addr), 32'h203);

      write_cell(8'h23, 7'h41);
      char_xy   = 8'h23;
      char_line = 4'd5;
      tick();
      chk("rd23_faddr", 32'(font_addr), 32'h415);
      tick();
      tick();
      chk("rd23_pix", 32'(char_pixels), 32'hA5);

      for (int i = 0; i < 16; i++) begin
         codes[i] = 7'(7'h30 + i * 3);
         write_cell(8'(8'h50 + i), codes[i]);
      end
      for (int j = 0; j < 18; j++) begin
         if (j < 16) begin
            char_xy   = 8'(8'h50 + j);
            char_line = 4'(j);
         end
         tick();
         if (j >= 2) begin
            chk("stream_pix", 32'(char_pixels),
                32'(rom_f({codes[j-2], 4'(j-2)})));
         end
      end

      wif.wr_valid = 1'b1;
      wif.wr_addr  = 8'h10;
      wif.wr_char  = 7'h42;
      char_xy      = 8'h10;
      char_line    = 4'd0;
      tick();
      wif.wr_valid = 1'b0;
      chk("coll_old", 32'(font_addr), 32'h200);
      tick();
      chk("coll_new", 32'(font_addr), 32'h420);

      wif.wr_valid = 1'b1;
      wif.wr_addr  = 8'h23;
      wif.wr_char  = 7'h7F;
      clear_req    = 1'b1;
      #1;
      chk("clr_wr_ready", 32'(wif.wr_ready), 32'd0);
      tick();
      clear_req    = 1'b0;
      wif.wr_valid = 1'b0;
      chk("clr_busy", 32'(busy), 32'd1);
      wait_idle(n);
      chk("clr_len", 32'(n), 32'd256);
      char_line = 4'd1;
      char_xy   = 8'h23;
      tick();
      chk("clr_c23", 32'(font_addr), 32'h201);
      char_xy = 8'h10;
      tick();
      chk("clr_c10", 32'(font_addr), 32'h201);
      char_xy = 8'h55;
      tick();
      chk("clr_c55", 32'(font_addr), 32'h201);

      pulse_clear();
      repeat (100) tick();
      chk("mid_busy", 32'(busy), 32'd1);
      pulse_clear();
      wait_idle(n);
      chk("restart_len", 32'(n), 32'd256);

      write_cell(8'h23, 7'h41);
      pulse_clear();
      repeat (50) tick();
      rst = 1'b1;
      wif.wr_valid = 1'b1;
      wif.wr_addr  = 8'h23;
      wif.wr_char  = 7'h41;
      repeat (2) tick();
      chk("rstmid_busy", 32'(busy), 32'd1);
      chk("rstmid_ready", 32'(wif.wr_ready), 32'd0);
      wif.wr_valid = 1'b0;
      rst = 1'b0;
      wait_idle(n);
      chk("rstmid_len", 32'(n), 32'd256);
      char_xy   = 8'h23;
      char_line = 4'd5;
      tick();
      chk("rstmid_drop", 32'(font_addr), 32'h205);

      write_cell(8'h23, 7'h41);
`ifdef CHAR_CURSOR_EN
      cursor_on = 1'b1;
`endif
      char_xy   = 8'h23;
      char_line = 4'd5;
      tick();
      char_xy   = 8'h24;
      tick();
      tick();
`ifdef CHAR_CURSOR_EN
      chk("cur_hit", 32'(char_pixels), 32'h5A);
`else
      chk("nocur_23", 32'(char_pixels), 32'hA5);
`endif
      tick();
      chk("cur_miss", 32'(char_pixels), 32'(rom_f(11'h205)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
